ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  EX-stage multiply/divide unit with architectural HI/LO registers. It consumes the forwarded
//  operands and md_op decoded in ID and carried through the ID/EX register.
//  It runs MULT/MULTU (fixed-latency) and DIV/DIVU (iterative, 33 cycles busy).
//  It serves MFHI/MFLO/MTHI/MTLO, and raises md_stall to the hazard unit, which drops the ID/EX en.
// PARAMETERS
//  MUL_CYCLES  3   cycles from MULT issue edge to HI/LO write; legal range 1..8
// PORTS
//  clk         in   1            system clock
//  rst         in   1            synchronous, active-high reset
//  ex_en       in   1            EX stage holds a live instruction this cycle (not bubble/frozen)
//  md_op       in   MD_OP_BIT    from ID/EX: NOP,MULT,MULTU,DIV,DIVU,MFHI,MFLO,MTHI,MTLO
//  md_data_a   in   32           rs operand after forwarding mux
//  md_data_b   in   32           rt operand after forwarding mux
//  cancel      in   1            abort in-flight op (exception/syscall flush)
//  md_stall    out  1            freeze IF/ID, ID/EX, PC this cycle
//  md_busy     out  1            MUL/DIV/FIX state active
//  md_done     out  1            1-cycle pulse on the edge-following cycle of the HI/LO write by MULT/DIV
//  md_result   out  32           MFHI->HI, MFLO->LO, else 0 (combinational)
//  hi, lo      out  32 each      architectural HI/LO
// BEHAVIOUR
//  Reset: state=IDLE, hi=lo=0, md_busy=0, md_done=0, counter=0, operand latches=0.
//    md_stall and md_result follow from these values.
//  Stall/accept rules:
//   - md_stall = md_busy & ex_en & (md_op!=NOP).
//   - accept   = ex_en & ~cancel & ~md_busy & (md_op!=NOP).
//  States: IDLE, MUL, DIV, FIX.
//  IDLE handling by op:
//   - MTHI/MTLO: hi/lo <= md_data_a at the accept edge. No state change.
//   - MFHI/MFLO: no state change. md_result reflects hi/lo in the same cycle.
//   - MULT/MULTU: latch a,b; counter <= MUL_CYCLES-1; ->MUL.
//       MULT multiplies sign-extended operands; MULTU multiplies zero-extended operands.
//   - DIV/DIVU: latch a,b; counter <= 31; ->DIV.
//       For DIV, latch |a|, |b|, q_neg=a[31]^b[31], r_neg=a[31].
//  MUL state:
//   - counter decrements each cycle.
//   - At counter==0: {hi,lo} <= 64-bit product; ->IDLE; md_done=1 the next cycle.
//   - MUL_CYCLES=1 means hi/lo are written at the edge after the issue edge.
//  DIV state:
//   - One restoring step per cycle (shift remainder, trial-subtract divisor).
//   - At counter==0: ->FIX.
//   - Busy window: 33 cycles after the issue edge. The unit returns to IDLE at issue edge +33.
//  FIX state:
//   - lo <= q_neg ? -q : q; hi <= r_neg ? -r : r.
//   - ->IDLE. md_done=1 the next cycle.
//  Divide by zero (not trapped, latency unchanged):
//   - lo = 32'hFFFF_FFFF; hi = dividend (original signed value for DIV).
//  Overflow case DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo = 32'h8000_0000, hi = 0.
//  Any md op in EX while busy (including the FIX cycle) stalls. It is accepted on the first idle cycle.
//  No HI/LO bypass to MFHI during FIX: MFHI stalls one cycle, then reads the new value.
//  Cancel:
//   - In MUL/DIV/FIX: ->IDLE next edge, hi/lo unchanged, no md_done.
//   - In the same cycle as an IDLE op: the op is not accepted. Cancel has priority.
//  Reset mid-operation: immediate return to reset values; pending result discarded.
//  Arithmetic: 64-bit product; negate is two's complement on 32 bits; all counters are 5 bits.
// STRUCTURE
//  Core.vh:
//   - MD_OP_BIT (4).
//   - MD_NOP=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MFHI=5, MD_MFLO=6,
//     MD_MTHI=7, MD_MTLO=8.
//  Sub-module md_divider: unsigned 32/32 restoring core.
//   - Ports: start, dividend, divisor, cancel -> quotient, remainder, done.
//   - Sign handling, the FIX state and HI/LO stay in ex_muldiv_unit.
// TESTING
//  1. MULT a=32'hFFFF_FFFE(-2), b=3, MUL_CYCLES=3
//     -> stall 0 at issue; busy 3 cycles; hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA; one md_done pulse.
//  2. MULTU a=b=32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001.
//  3. DIV -7/2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF, 33 busy cycles.
//     MFHI issued the next cycle stalls exactly 33 cycles, then md_result=32'hFFFF_FFFF.
//  4. DIVU 100/0 -> lo=32'hFFFF_FFFF, hi=100.
//     DIV 32'h8000_0000/-1 -> lo=32'h8000_0000, hi=0.
//  5. DIVU issued, cancel at busy cycle 10 -> IDLE next cycle, hi/lo unchanged, no md_done.
//     MTLO 5 with cancel=1 -> lo unchanged.
//  6. rst=1 during DIV cycle 20 -> hi=lo=0, busy=0 next cycle.
//     MTHI 32'h1234 back-to-back with MFHI -> md_result=32'h1234, no stall.

Source files
------------

// File: rtl/ex_muldiv_unit_pkg.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit_pkg
// Shared definitions for the EX-stage multiply/divide unit.
//   DATA_W     : datapath width of operands and HI/LO
//   MD_OP_BIT  : width of the md_op code carried in the ID/EX register
//   md_op_t    : md_op code type, MD_* constants are the decoded operations
//   neg32()    : two's-complement negate on the datapath width
// ----------------------------------------------------------------------------
package ex_muldiv_unit_pkg;

    localparam int DATA_W    = 32;
    localparam int MD_OP_BIT = 4;

    typedef logic [MD_OP_BIT-1:0] md_op_t;

    localparam md_op_t MD_NOP   = 4'd0;
    localparam md_op_t MD_MULT  = 4'd1;
    localparam md_op_t MD_MULTU = 4'd2;
    localparam md_op_t MD_DIV   = 4'd3;
    localparam md_op_t MD_DIVU  = 4'd4;
    localparam md_op_t MD_MFHI  = 4'd5;
    localparam md_op_t MD_MFLO  = 4'd6;
    localparam md_op_t MD_MTHI  = 4'd7;
    localparam md_op_t MD_MTLO  = 4'd8;

    function automatic logic [DATA_W-1:0] neg32(input logic [DATA_W-1:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit_if
// Bundle between the pipeline (master) and the multiply/divide unit (slave).
//   ex_en      : EX holds a live instruction
//   md_op      : decoded md operation from ID/EX
//   md_data_a  : forwarded rs operand
//   md_data_b  : forwarded rt operand
//   cancel     : flush of the in-flight md operation
//   md_stall   : freeze request to the hazard unit
//   md_busy    : MUL/DIV/FIX active
//   md_done    : one-cycle pulse after a MULT/DIV result lands in HI/LO
//   md_result  : MFHI/MFLO read data
//   hi, lo     : architectural HI/LO
// ----------------------------------------------------------------------------
interface ex_muldiv_unit_if;
    import ex_muldiv_unit_pkg::*;

    logic              ex_en;
    md_op_t            md_op;
    logic [DATA_W-1:0] md_data_a;
    logic [DATA_W-1:0] md_data_b;
    logic              cancel;
    logic              md_stall;
    logic              md_busy;
    logic              md_done;
    logic [DATA_W-1:0] md_result;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output ex_en, md_op, md_data_a, md_data_b, cancel,
        input  md_stall, md_busy, md_done, md_result, hi, lo
    );

    modport slave (
        input  ex_en, md_op, md_data_a, md_data_b, cancel,
        output md_stall, md_busy, md_done, md_result, hi, lo
    );

endinterface

// File: rtl/ex_muldiv_unit_md_divider.sv
// ----------------------------------------------------------------------------
// md_divider
// Unsigned 32/32 restoring divider, one quotient bit per cycle (32 steps).
//   clk, rst   : clock, synchronous active-high reset
//   start      : load dividend/divisor and begin
//   dividend   : unsigned dividend
//   divisor    : unsigned divisor (0 yields quotient all-ones, remainder=dividend)
//   cancel     : abandon the running division
//   quotient   : final quotient, valid while done is high
//   remainder  : final remainder, valid while done is high
//   done       : one-cycle pulse in the cycle after the last step
// ----------------------------------------------------------------------------
module md_divider
    import ex_muldiv_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    input  logic              cancel,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              done
);

    logic              r_run;
    logic              r_done;
    logic [4:0]        r_cnt;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_dvsr;

    logic [DATA_W:0]   w_shift;
    logic [DATA_W:0]   w_diff;

    // Remainder:quotient shift left by one; the dividend bits drain out of
    // r_quo's MSB while quotient bits fill in at its LSB.
    assign w_shift = {r_rem, r_quo[DATA_W-1]};
    assign w_diff  = w_shift - {1'b0, r_dvsr};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run  <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= 5'd0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvsr <= '0;
        end else begin
            r_done <= 1'b0;
            if (cancel) begin
                r_run <= 1'b0;
            end else if (start) begin
                r_run  <= 1'b1;
                r_cnt  <= 5'd31;
                r_rem  <= '0;
                r_quo  <= dividend;
                r_dvsr <= divisor;
            end else if (r_run) begin
                // Trial subtract; keep the difference only if it did not borrow.
                if (!w_diff[DATA_W]) begin
                    r_rem <= w_diff[DATA_W-1:0];
                    r_quo <= {r_quo[DATA_W-2:0], 1'b1};
                end else begin
                    r_rem <= w_shift[DATA_W-1:0];
                    r_quo <= {r_quo[DATA_W-2:0], 1'b0};
                end
                r_cnt <= r_cnt - 5'd1;
                if (r_cnt == 5'd0) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;
    assign done      = r_done;

endmodule

// File: rtl/ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit
// EX-stage multiply/divide unit owning the architectural HI/LO registers.
// MULT/MULTU complete MUL_CYCLES cycles after issue; DIV/DIVU run 32 restoring
// steps plus one sign-fix cycle (33 busy cycles). MFHI/MFLO read combinationally,
// MTHI/MTLO write at the accept edge. Any md op seen while busy raises md_stall.
//   clk, rst   : clock, synchronous active-high reset
//   md_if      : slave side of ex_muldiv_unit_if (operands, op, cancel in;
//                md_stall, md_busy, md_done, md_result, hi, lo out)
// Parameter MUL_CYCLES (1..8): cycles from MULT issue edge to HI/LO write.
// ----------------------------------------------------------------------------
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int MUL_CYCLES = 3
) (
    input  logic            clk,
    input  logic            rst,
    ex_muldiv_unit_if.slave md_if
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    logic [1:0]        r_state;
    logic [4:0]        r_cnt;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic              r_mul_signed;
    logic              r_q_neg;
    logic              r_r_neg;
    logic              r_done;

    logic                     w_busy;
    logic                     w_is_md_op;
    logic                     w_accept;
    logic                     w_signed_div;
    logic                     w_div_start;
    logic [DATA_W-1:0]        w_div_dividend;
    logic [DATA_W-1:0]        w_div_divisor;
    logic [DATA_W-1:0]        w_div_quo;
    logic [DATA_W-1:0]        w_div_rem;
    logic                     w_div_done;
    logic signed [2*DATA_W-1:0] w_mul_a;
    logic signed [2*DATA_W-1:0] w_mul_b;
    logic signed [2*DATA_W-1:0] w_prod;

    assign w_busy     = (r_state != ST_IDLE);
    assign w_is_md_op = (md_if.md_op != MD_NOP);
    assign w_accept   = md_if.ex_en & ~md_if.cancel & ~w_busy & w_is_md_op;

    assign w_signed_div = (md_if.md_op == MD_DIV);
    assign w_div_start  = w_accept & ((md_if.md_op == MD_DIV) | (md_if.md_op == MD_DIVU));

    // The divider core is unsigned; signed DIV feeds it magnitudes and the
    // signs are restored in FIX. |0x8000_0000| stays 0x8000_0000, which as an
    // unsigned magnitude is exactly right.
    assign w_div_dividend = (w_signed_div && md_if.md_data_a[DATA_W-1]) ?
                            neg32(md_if.md_data_a) : md_if.md_data_a;
    assign w_div_divisor  = (w_signed_div && md_if.md_data_b[DATA_W-1]) ?
                            neg32(md_if.md_data_b) : md_if.md_data_b;

    // A 64x64 product truncated to 64 bits gives the exact 32x32 result for
    // both sign- and zero-extended operands.
    assign w_mul_a = {{DATA_W{r_mul_signed & r_op_a[DATA_W-1]}}, r_op_a};
    assign w_mul_b = {{DATA_W{r_mul_signed & r_op_b[DATA_W-1]}}, r_op_b};
    assign w_prod  = w_mul_a * w_mul_b;

    md_divider u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (w_div_start),
        .dividend  (w_div_dividend),
        .divisor   (w_div_divisor),
        .cancel    (md_if.cancel),
        .quotient  (w_div_quo),
        .remainder (w_div_rem),
        .done      (w_div_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 5'd0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_mul_signed <= 1'b0;
            r_q_neg      <= 1'b0;
            r_r_neg      <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (md_if.md_op)
                            MD_MTHI: r_hi <= md_if.md_data_a;
                            MD_MTLO: r_lo <= md_if.md_data_a;
                            MD_MULT, MD_MULTU: begin
                                r_op_a       <= md_if.md_data_a;
                                r_op_b       <= md_if.md_data_b;
                                r_mul_signed <= (md_if.md_op == MD_MULT);
                                r_cnt        <= 5'(MUL_CYCLES - 1);
                                r_state      <= ST_MUL;
                            end
                            MD_DIV, MD_DIVU: begin
                                r_op_a  <= md_if.md_data_a;
                                r_op_b  <= md_if.md_data_b;
                                r_q_neg <= w_signed_div &
                                           (md_if.md_data_a[DATA_W-1] ^ md_if.md_data_b[DATA_W-1]);
                                r_r_neg <= w_signed_div & md_if.md_data_a[DATA_W-1];
                                r_cnt   <= 5'd31;
                                r_state <= ST_DIV;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (md_if.cancel) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == 5'd0) begin
                        {r_hi, r_lo} <= w_prod;
                        r_state      <= ST_IDLE;
                        r_done       <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                ST_DIV: begin
                    if (md_if.cancel) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == 5'd0) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                ST_FIX: begin
                    // The divider's done pulse marks the cycle its quotient and
                    // remainder are final, which coincides with FIX.
                    if (md_if.cancel) begin
                        r_state <= ST_IDLE;
                    end else if (w_div_done) begin
                        if (r_op_b == '0) begin
                            // Divide by zero: fixed all-ones quotient, the
                            // original (signed) dividend as remainder.
                            r_lo <= '1;
                            r_hi <= r_op_a;
                        end else begin
                            r_lo <= r_q_neg ? neg32(w_div_quo) : w_div_quo;
                            r_hi <= r_r_neg ? neg32(w_div_rem) : w_div_rem;
                        end
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign md_if.md_stall  = w_busy & md_if.ex_en & w_is_md_op;
    assign md_if.md_busy   = w_busy;
    assign md_if.md_done   = r_done;
    assign md_if.md_result = (md_if.md_op == MD_MFHI) ? r_hi :
                             (md_if.md_op == MD_MFLO) ? r_lo : '0;
    assign md_if.hi        = r_hi;
    assign md_if.lo        = r_lo;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_ex_muldiv_unit
// Directed bench for ex_muldiv_unit (MUL_CYCLES=3): a table of MULT/DIV
// vectors with hand-computed HI/LO and busy lengths, followed by hand-written
// sequences for stall-through-FIX, cancel, reset mid-divide and MTHI/MFHI.
// ----------------------------------------------------------------------------
module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

    localparam int TB_MUL = 3;

    typedef struct {
        md_op_t      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[13];

    always #5 clk = ~clk;

    ex_muldiv_unit_if u_if();

    ex_muldiv_unit #(.MUL_CYCLES(TB_MUL)) dut (
        .clk   (clk),
        .rst   (rst),
        .md_if (u_if)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input md_op_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic can);
        u_if.ex_en     = en;
        u_if.md_op     = op;
        u_if.md_data_a = a;
        u_if.md_data_b = b;
        u_if.cancel    = can;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic observe(input int n, output int busy_n, output int done_n);
        busy_n = 0;
        done_n = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (u_if.md_busy) busy_n++;
            if (u_if.md_done) done_n++;
        end
    endtask

    initial begin
        int bn, dn, stall_n;
        bit seen;

        vecs[0]  = '{MD_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, TB_MUL};
        vecs[1]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, TB_MUL};
        vecs[2]  = '{MD_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, TB_MUL};
        vecs[3]  = '{MD_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, TB_MUL};
        vecs[4]  = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        vecs[5]  = '{MD_DIVU,  32'd100,       32'd0,        32'd100,       32'hFFFF_FFFF, 33};
        vecs[6]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
        vecs[7]  = '{MD_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        33};
        vecs[8]  = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33};
        vecs[9]  = '{MD_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2,         33};
        vecs[10] = '{MD_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 33};
        vecs[11] = '{MD_DIVU,  32'hFFFF_FFFF, 32'd1,        32'd0,         32'hFFFF_FFFF, 33};
        vecs[12] = '{MD_DIVU,  32'h8000_0000, 32'd3,        32'd2,         32'h2AAA_AAAA, 33};

        // Reset state
        rst = 1'b1;
        drive(1'b0, MD_NOP, 32'd0, 32'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_hi", u_if.hi, 32'd0);
        chk("rst_lo", u_if.lo, 32'd0);
        chk("rst_busy", 32'(u_if.md_busy), 32'd0);
        chk("rst_done", 32'(u_if.md_done), 32'd0);
        tick;
        drive(1'b1, MD_MFHI, 32'd0, 32'd0, 1'b0);
        #1;
        chk("rst_result", u_if.md_result, 32'd0);
        chk("rst_stall", 32'(u_if.md_stall), 32'd0);

        // Table-driven MULT/DIV vectors
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
            @(negedge clk);
            chk($sformatf("vec%0d_issue_stall", i), 32'(u_if.md_stall), 32'd0);
            tick;
            drive(1'b0, MD_NOP, 32'd0, 32'd0, 1'b0);
            observe(45, bn, dn);
            chk($sformatf("vec%0d_busy_cycles", i), 32'(bn), 32'(vecs[i].busy));
            chk($sformatf("vec%0d_done_pulses", i), 32'(dn), 32'd1);
            chk($sformatf("vec%0d_hi", i), u_if.hi, vecs[i].hi);
            chk($sformatf("vec%0d_lo", i), u_if.lo, vecs[i].lo);
            tick;
            drive(1'b1, MD_MFHI, 32'd0, 32'd0, 1'b0);
            #1;
            chk($sformatf("vec%0d_mfhi", i), u_if.md_result, vecs[i].hi);
            drive(1'b1, MD_MFLO, 32'd0, 32'd0, 1'b0);
            #1;
            chk($sformatf("vec%0d_mflo", i), u_if.md_result, vecs[i].lo);
            drive(1'b0, MD_NOP, 32'd0, 32'd0, 1'b0);
            tick;
        end

        // MFHI right behind a DIV stalls through DIV and FIX, then reads new HI
        drive(1'b1, MD_MTHI, 32'd0, 32'd0, 1'b0);
        tick;
        drive(1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        tick;
        drive(1'b1, MD_MFHI, 32'd0, 32'd0, 1'b0);
        stall_n = 0;
        seen    = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (u_if.md_stall) stall_n++;
            else seen = 1'b1;
        end
        chk("mfhi_stall_cycles", 32'(stall_n), 32'd33);
        chk("mfhi_after_div", u_if.md_result, 32'hFFFF_FFFF);
        tick;

        // DIVU cancelled in busy cycle 10
        drive(1'b1, MD_MTHI, 32'hAAAA_AAAA, 32'd0, 1'b0);
        tick;
        drive(1'b1, MD_MTLO, 32'h5555_5555, 32'd0, 1'b0);
        tick;
        drive(1'b1, MD_DIVU, 32'd100, 32'd7, 1'b0);
        tick;
        drive(1'b0, MD_NOP, 32'd0, 32'd0, 1'b0);
        repeat (9) tick;
        drive(1'b0, MD_NOP, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        chk("cancel_busy_before", 32'(u_if.md_busy), 32'd1);
        tick;
        drive(1'b0, MD_NOP, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("cancel_busy_after", 32'(u_if.md_busy), 32'd0);
        observe(40, bn, dn);
        chk("cancel_no_done", 32'(dn), 32'd0);
        chk("cancel_hi_kept", u_if.hi, 32'hAAAA_AAAA);
        chk("cancel_lo_kept", u_if.lo, 32'h5555_5555);

        // MTLO together with cancel is dropped
        tick;
        drive(1'b1, MD_MTLO, 32'd5, 32'd0, 1'b1);
        tick;
        drive(1'b0, MD_NOP, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("mtlo_cancel_lo", u_if.lo, 32'h5555_5555);

        // Reset in DIV busy cycle 20
        tick;
        drive(1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        tick;
        drive(1'b0, MD_NOP, 32'd0, 32'd0, 1'b0);
        repeat (19) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_hi", u_if.hi, 32'd0);
        chk("midrst_lo", u_if.lo, 32'd0);
        chk("midrst_busy", 32'(u_if.md_busy), 32'd0);
        observe(40, bn, dn);
        chk("midrst_no_done", 32'(dn), 32'd0);
        chk("midrst_lo_later", u_if.lo, 32'd0);

        // MTHI then MFHI back-to-back
        tick;
        drive(1'b1, MD_MTHI, 32'h0000_1234, 32'd0, 1'b0);
        @(negedge clk);
        chk("mthi_stall", 32'(u_if.md_stall), 32'd0);
        tick;
        drive(1'b1, MD_MFHI, 32'd0, 32'd0, 1'b0);
        #1;
        chk("mfhi_b2b_result", u_if.md_result, 32'h0000_1234);
        @(negedge clk);
        chk("mfhi_b2b_stall", 32'(u_if.md_stall), 32'd0);
        tick;
        drive(1'b0, MD_NOP, 32'd0, 32'd0, 1'b0);
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
